wb_proj_ctrl: RTL and testbench
===============================

WB_PROJ_CTRL -- requirements
Module: wb_proj_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base; decode compares wbs_adr_i[31:4] to BASE_ADDR[31:4].
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, reset value of the HOLD register (8 bits).
REQ-003 SHALL have port wb_clk_i  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port wb_rst_i  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic cycle/strobe/write.
REQ-006 SHALL have ports wbs_sel_i  in  4, wbs_adr_i  in  32, wbs_dat_i  in  32  byte lanes/address/write data.
REQ-007 SHALL have ports wbs_ack_o  out  1, wbs_dat_o  out  32  acknowledge/read data.
REQ-008 SHALL have ports rst_blinker, rst_sid, rst_sn76489, rst_qcpu  out  1 each  active-low project resets.
REQ-009 SHALL have port custom_settings  out  32  applied settings word to projects.
REQ-010 SHALL have port irq  out  1  reset-sequence-complete pulse.

Function
REQ-011 Register map (wbs_adr_i[3:2]): 0 CTRL [1:0] sel (0 blinker, 1 sid, 2 sn76489, 3 qcpu), [2] en; 1 SETTINGS shadow [31:0]; 2 HOLD [7:0]; 3 STATUS read-only [1:0] active sel, [2] busy (HOLD state), [3] running (RUN state).
REQ-012 Access accepted in cycle with cyc & stb & !ack; ack high exactly the following cycle, one cycle; never two consecutive ack cycles.
REQ-013 Write takes effect on the accepting edge; SETTINGS honours wbs_sel_i per byte lane; CTRL/HOLD write only when wbs_sel_i[0]=1.
REQ-014 Read data registered with ack; unused bits read 0; CTRL/HOLD read back stored values.
REQ-015 Address outside BASE_ADDR decode: acked normally, read data 0, no state change.
REQ-016 FSM states IDLE, HOLD, RUN; reset enters IDLE.
REQ-017 Any accepted CTRL write, any state: enter HOLD, counter loaded with max(HOLD,1), all four project resets low, including restart when already in HOLD.
REQ-018 HOLD: counter decrements each cycle; exits on the edge where counter==1, so HOLD lasts exactly max(HOLD,1) cycles.
REQ-019 HOLD exit with CTRL.en=1: enter RUN, copy SETTINGS shadow to custom_settings, latch sel as active sel; with en=0: enter IDLE, custom_settings unchanged.
REQ-020 RUN: only the project resets matching active sel high; others low; SETTINGS writes in RUN update shadow only, not custom_settings.
REQ-021 IDLE and HOLD: all project resets low.
REQ-022 Project reset outputs and custom_settings registered; no combinational path from Wishbone inputs.

Reset
REQ-023 wb_rst_i high at an edge: state IDLE, CTRL=0, SETTINGS shadow=0, custom_settings=0, HOLD=HOLD_CYCLES, counter=0, all project resets low, ack=0, wbs_dat_o=0, irq=0.
REQ-024 Reset mid-transaction or mid-HOLD SHALL abort it; no ack issued for a transaction pending at reset.

Configuration
REQ-025 Macro WB_PROJ_CTRL_IRQ_EN defined: irq pulses high one cycle, the cycle after HOLD->RUN transition; HOLD->IDLE gives no pulse.
REQ-026 Macro WB_PROJ_CTRL_IRQ_EN undefined: irq tied 0, no irq logic synthesised; all else identical.

Verification
REQ-027 Reset, read all four registers -> 0, 0, HOLD_CYCLES (16), 0; all project resets low; custom_settings 0.
REQ-028 Write SETTINGS 32'hA5A5_1234, HOLD 4, CTRL 3'b111 -> exactly 4 cycles busy, then rst_qcpu high, others low, custom_settings 32'hA5A5_1234, STATUS 4'b1011.
REQ-029 In RUN write SETTINGS 32'h0000_00FF sel 4'b0001 -> custom_settings unchanged; later CTRL 3'b101 -> after HOLD, rst_sid high, custom_settings 32'hA5A5_12FF.
REQ-030 HOLD 10, CTRL write, second CTRL write 5 cycles later -> busy persists 10 cycles after second write; single irq pulse (IRQ_EN defined).
REQ-031 HOLD 0, CTRL 3'b010 (en=0) -> 1 busy cycle, then IDLE, all resets low, irq stays 0.
REQ-032 Read address 0x3000_0010 -> acked next cycle, data 0; wb_rst_i asserted mid-HOLD -> next cycle all REQ-023 values.

Source files
------------

// File: rtl/wb_proj_ctrl_if.sv
// Wishbone classic slave bundle for the project reset controller.
interface wb_proj_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_proj_ctrl.sv
// Wishbone-controlled project selector: holds all project resets low for a programmable
// time after each CTRL write, then releases the selected one. Optional irq: WB_PROJ_CTRL_IRQ_EN.
//
// state | meaning
// IDLE  | no project running, all project resets low
// HOLD  | reset hold timer counting down, all project resets low
// RUN   | active project out of reset, settings applied
module wb_proj_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          HOLD_CYCLES = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_proj_ctrl_if.slave      wbs,
  output logic               rst_blinker,
  output logic               rst_sid,
  output logic               rst_sn76489,
  output logic               rst_qcpu,
  output logic [31:0]        custom_settings,
  output logic               irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t      state_q, state_nxt;
  logic [7:0]  cnt_q, cnt_nxt;
  logic [2:0]  ctrl_q;
  logic [31:0] shadow_q;
  logic [7:0]  hold_q;
  logic [1:0]  act_sel_q, act_sel_nxt;
  logic [3:0]  prst_q;
  logic [31:0] settings_q;
  logic        ack_q;
  logic [31:0] dat_q;
  logic [31:0] rd_data;

  logic        accept, hit, wr, ctrl_wr, enter_run;
  logic [1:0]  reg_sel;

  wire unused_adr_lsb = &{1'b0, wbs.wbs_adr_i[1:0]};

  always_comb begin
    reg_sel = wbs.wbs_adr_i[3:2];
    accept  = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
    hit     = (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    wr      = accept & hit & wbs.wbs_we_i;
    ctrl_wr = wr & (reg_sel == 2'd0) & wbs.wbs_sel_i[0];
  end

  // A CTRL write restarts the hold from any state, including a hold in progress.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    if (ctrl_wr) begin
      state_nxt = ST_HOLD;
      cnt_nxt   = (hold_q == 8'd0) ? 8'd1 : hold_q;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == 8'd1) begin
            state_nxt = ctrl_q[2] ? ST_RUN : ST_IDLE;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = cnt_q - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    enter_run   = (state_q == ST_HOLD) && (state_nxt == ST_RUN);
    act_sel_nxt = enter_run ? ctrl_q[1:0] : act_sel_q;
  end

  always_comb begin
    rd_data = 32'd0;
    case (reg_sel)
      2'd0: rd_data = {29'd0, ctrl_q};
      2'd1: rd_data = shadow_q;
      2'd2: rd_data = {24'd0, hold_q};
      2'd3: rd_data = {28'd0, state_q == ST_RUN, state_q == ST_HOLD, act_sel_q};
      default: rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrl_q     <= 3'd0;
      shadow_q   <= 32'd0;
      hold_q     <= 8'(HOLD_CYCLES);
      act_sel_q  <= 2'd0;
      prst_q     <= 4'd0;
      settings_q <= 32'd0;
      ack_q      <= 1'b0;
      dat_q      <= 32'd0;
    end else begin
      ack_q <= accept;
      dat_q <= (accept && hit && !wbs.wbs_we_i) ? rd_data : 32'd0;
      if (wr) begin
        case (reg_sel)
          2'd0: if (wbs.wbs_sel_i[0]) ctrl_q <= wbs.wbs_dat_i[2:0];
          2'd1: begin
            for (int b = 0; b < 4; b++) begin
              if (wbs.wbs_sel_i[b]) shadow_q[8*b +: 8] <= wbs.wbs_dat_i[8*b +: 8];
            end
          end
          2'd2: if (wbs.wbs_sel_i[0]) hold_q <= wbs.wbs_dat_i[7:0];
          default: ;
        endcase
      end
      if (enter_run) settings_q <= shadow_q;
      act_sel_q <= act_sel_nxt;
      prst_q    <= (state_nxt == ST_RUN) ? (4'd1 << act_sel_nxt) : 4'd0;
    end
  end

  assign wbs.wbs_ack_o   = ack_q;
  assign wbs.wbs_dat_o   = dat_q;
  assign rst_blinker     = prst_q[0];
  assign rst_sid         = prst_q[1];
  assign rst_sn76489     = prst_q[2];
  assign rst_qcpu        = prst_q[3];
  assign custom_settings = settings_q;

`ifdef WB_PROJ_CTRL_IRQ_EN
  logic irq_q;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) irq_q <= 1'b0;
    else          irq_q <= enter_run;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_wb_proj_ctrl.sv
// Self-checking bench for wb_proj_ctrl: directed scenarios plus random bus traffic
// compared against a timestamp-based model of the hold/run behaviour.
module tb_wb_proj_ctrl;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_blinker, rst_sid, rst_sn76489, rst_qcpu, irq;
  logic [31:0] custom_settings;

  wb_proj_ctrl_if bus ();

  wb_proj_ctrl #(.BASE_ADDR(BASE), .HOLD_CYCLES(16)) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .wbs             (bus.slave),
    .rst_blinker     (rst_blinker),
    .rst_sid         (rst_sid),
    .rst_sn76489     (rst_sn76489),
    .rst_qcpu        (rst_qcpu),
    .custom_settings (custom_settings),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;
  int irq_cnt = 0;
  bit mon_en = 0;

  always @(posedge clk) ecnt++;
  always @(negedge clk) if (irq === 1'b1) irq_cnt++;

  // Model: a pending hold ends at an absolute edge number; outcome resolved lazily.
  logic [2:0]  m_ctrl;
  logic [31:0] m_shadow, m_custom;
  logic [7:0]  m_hold;
  logic [1:0]  m_active;
  bit          m_run, m_pending;
  int          m_hold_end, m_irq_edge;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at edge %0d", tag, obs, exp, ecnt);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 0; m_shadow = 0; m_custom = 0; m_hold = 8'd16; m_active = 0;
    m_run = 0; m_pending = 0; m_hold_end = 0; m_irq_edge = -1;
  endtask

  task automatic settle(input int t, input bit is_ctrl);
    if (m_pending && (m_hold_end < t || (m_hold_end == t && !is_ctrl))) begin
      m_pending = 0;
      if (m_ctrl[2]) begin
        m_run = 1; m_custom = m_shadow; m_active = m_ctrl[1:0]; m_irq_edge = m_hold_end;
      end else begin
        m_run = 0;
      end
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] r);
    case (r)
      2'd0: return {29'd0, m_ctrl};
      2'd1: return m_shadow;
      2'd2: return {24'd0, m_hold};
      default: return {28'd0, m_run && !m_pending, m_pending, m_active};
    endcase
  endfunction

  task automatic model_write(input int k, input logic [1:0] r, input logic [3:0] sel,
                             input logic [31:0] dat);
    case (r)
      2'd0: if (sel[0]) begin
        m_ctrl = dat[2:0]; m_pending = 1; m_run = 0;
        m_hold_end = k + ((m_hold == 0) ? 1 : int'(m_hold));
      end
      2'd1: for (int b = 0; b < 4; b++) if (sel[b]) m_shadow[8*b +: 8] = dat[8*b +: 8];
      2'd2: if (sel[0]) m_hold = dat[7:0];
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [3:0] exp_prst;
      settle(ecnt, 0);
      exp_prst = (m_run && !m_pending) ? (4'd1 << m_active) : 4'd0;
      check("proj_resets", {28'd0, rst_qcpu, rst_sn76489, rst_sid, rst_blinker}, {28'd0, exp_prst});
      check("custom_settings", custom_settings, m_custom);
`ifdef WB_PROJ_CTRL_IRQ_EN
      check("irq", {31'd0, irq}, {31'd0, m_irq_edge == ecnt});
`else
      check("irq", {31'd0, irq}, 32'd0);
`endif
    end
  end

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output logic [31:0] rdat);
    int k;
    bit hit, is_ctrl;
    logic [31:0] rd_exp;
    @(negedge clk);
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr; bus.wbs_sel_i = sel; bus.wbs_dat_i = dat;
    @(posedge clk); #1;
    k = ecnt;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    hit = (adr[31:4] == BASE[31:4]);
    settle(k - 1, 0);
    rd_exp = (hit && !we) ? model_read(adr[3:2]) : 32'd0;
    is_ctrl = hit && we && (adr[3:2] == 2'd0) && sel[0];
    settle(k, is_ctrl);
    if (hit && we) model_write(k, adr[3:2], sel, dat);
    check("ack", {31'd0, bus.wbs_ack_o}, 32'd1);
    check("rdata", bus.wbs_dat_o, rd_exp);
    rdat = bus.wbs_dat_o;
    @(posedge clk); #1;
    check("ack_single", {31'd0, bus.wbs_ack_o}, 32'd0);
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] sel = 4'hF);
    logic [31:0] rd;
    wb_xfer(1'b1, BASE + {28'd0, r, 2'b00}, sel, d, rd);
  endtask

  task automatic rd(input logic [1:0] r, output logic [31:0] d);
    wb_xfer(1'b0, BASE + {28'd0, r, 2'b00}, 4'hF, 32'd0, d);
  endtask

  initial begin
    logic [31:0] d;
    int irq0;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0; mon_en = 1;

    // Reset values
    rd(2'd0, d); check("rst_ctrl", d, 32'd0);
    rd(2'd1, d); check("rst_settings", d, 32'd0);
    rd(2'd2, d); check("rst_hold", d, 32'd16);
    rd(2'd3, d); check("rst_status", d, 32'd0);

    // Basic run of qcpu
    irq0 = irq_cnt;
    wr(2'd1, 32'hA5A5_1234);
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h7);
    repeat (2) @(posedge clk); #1;
    check("qcpu_held", {31'd0, rst_qcpu}, 32'd0);
    @(posedge clk); #1;
    check("qcpu_run", {31'd0, rst_qcpu}, 32'd1);
    check("settings_applied", custom_settings, 32'hA5A5_1234);
    rd(2'd3, d); check("status_run", d, 32'hB);

    // Shadow-only update in RUN, then switch to sid
    wr(2'd1, 32'h0000_00FF, 4'b0001);
    check("settings_unchanged", custom_settings, 32'hA5A5_1234);
    wr(2'd0, 32'h5);
    repeat (3) @(posedge clk); #1;
    check("sid_run", {28'd0, rst_qcpu, rst_sn76489, rst_sid, rst_blinker}, 32'h2);
    check("settings_merged", custom_settings, 32'hA5A5_12FF);

    // Restart during HOLD
    wr(2'd2, 32'd10);
    irq0 = irq_cnt;
    wr(2'd0, 32'h4);
    repeat (3) @(posedge clk);
    wr(2'd0, 32'h4);
    repeat (8) @(posedge clk); #1;
    check("restart_held", {31'd0, rst_blinker}, 32'd0);
    @(posedge clk); #1;
    check("restart_run", {31'd0, rst_blinker}, 32'd1);
    repeat (2) @(posedge clk);
`ifdef WB_PROJ_CTRL_IRQ_EN
    check("irq_count_restart", irq_cnt - irq0, 32'd1);
`else
    check("irq_count_restart", irq_cnt - irq0, 32'd0);
`endif

    // HOLD 0 with en=0
    wr(2'd2, 32'd0);
    irq0 = irq_cnt;
    wr(2'd0, 32'h2);
    check("idle_resets", {28'd0, rst_qcpu, rst_sn76489, rst_sid, rst_blinker}, 32'd0);
    rd(2'd3, d); check("status_idle", d, 32'd0);
    check("irq_none_idle", irq_cnt - irq0, 32'd0);

    // Out-of-range address
    wb_xfer(1'b0, BASE + 32'h10, 4'hF, 32'd0, d); check("oor_read", d, 32'd0);
    wb_xfer(1'b1, BASE + 32'h14, 4'hF, 32'hFFFF_FFFF, d);
    rd(2'd1, d); check("oor_no_write", d, 32'hA5A5_12FF);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      logic [1:0] r;
      logic [31:0] dat, adr;
      logic wen;
      r = 2'($urandom_range(0, 3));
      wen = 1'($urandom_range(0, 1));
      dat = $urandom;
      if (r == 2'd2) dat[7:0] = 8'($urandom_range(0, 6));
      adr = ($urandom_range(0, 9) == 0) ? (BASE + 32'h20 + {28'd0, r, 2'b00})
                                         : (BASE + {28'd0, r, 2'b00});
      wb_xfer(wen, adr, 4'($urandom), dat, d);
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    repeat (10) @(posedge clk);

    // Reset mid-HOLD with a transaction pending
    wr(2'd2, 32'd10);
    wr(2'd0, 32'h7);
    @(negedge clk);
    rst = 1;
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = BASE;
    @(posedge clk); #1;
    model_reset();
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    check("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    check("rst_dat", bus.wbs_dat_o, 32'd0);
    check("rst_prst", {28'd0, rst_qcpu, rst_sn76489, rst_sid, rst_blinker}, 32'd0);
    check("rst_custom", custom_settings, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    check("rst_no_late_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    rd(2'd0, d); check("post_rst_ctrl", d, 32'd0);
    rd(2'd1, d); check("post_rst_settings", d, 32'd0);
    rd(2'd2, d); check("post_rst_hold", d, 32'd16);
    rd(2'd3, d); check("post_rst_status", d, 32'd0);
    repeat (20) @(posedge clk);

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
